dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single-port synchronous data RAM between the pipeline MEM stage (CPU port)
//  and a DMA/loader port that fills or inspects memory while the core runs.
//  - Sits between the MEM-stage address/data mux and the RAM instance.
//  - CPU has fixed priority. When the CPU port loses arbitration, the block stalls the pipeline.
//  - The DMA port uses a req/ack handshake with one-cycle read latency.
// PARAMETERS
//  DATA_W    32  data width of both ports and the RAM
//  ADDR_W    5   RAM word-address width (32 words)
//  MAX_WAIT  8   DMA wait-cycle limit before a forced grant (range 1..255; starvation guard only)
// PORTS
//  clock      in   1       rising-edge clock; also clocks the RAM
//  reset      in   1       asynchronous, active-high reset
//  cpu_req    in   1       MEM stage accesses data RAM this cycle
//  cpu_we     in   1       CPU write enable (qualified by cpu_req)
//  cpu_addr   in   ADDR_W  CPU word address
//  cpu_wdata  in   DATA_W  CPU write data
//  cpu_rdata  out  DATA_W  CPU read data (= ram_rdata)
//  cpu_stall  out  1       CPU access not performed this cycle; pipeline must hold
//  dma_req    in   1       DMA request; held until dma_ack
//  dma_we     in   1       DMA write enable; stable while dma_req is high
//  dma_addr   in   ADDR_W  DMA word address; stable while dma_req is high
//  dma_wdata  in   DATA_W  DMA write data; stable while dma_req is high
//  dma_ack    out  1       one-cycle pulse: DMA access complete
//  dma_rdata  out  DATA_W  DMA read data; valid with dma_ack, held until next ack
//  ram_addr   out  ADDR_W  to RAM
//  ram_we     out  1       to RAM
//  ram_wdata  out  DATA_W  to RAM
//  ram_rdata  in   DATA_W  from RAM; valid one cycle after address
// BEHAVIOUR
//  - Grant is combinational in cycle t. The RAM samples addr/we/wdata at the end of t.
//    Read data appears on ram_rdata in t+1.
//  - States:
//    - IDLE: no DMA completion pending.
//    - DMA_ACK: entered the cycle after a DMA grant. Asserts dma_ack, then returns to IDLE.
//  - Grant rules:
//    - DMA is never granted in DMA_ACK, so back-to-back DMA accesses run at most one per 2 cycles.
//    - CPU is granted whenever cpu_req=1 and DMA is not forced.
//    - DMA is granted in IDLE if dma_req=1 and (cpu_req=0 or forced).
//  - RAM muxing:
//    - ram_* follow the granted port.
//    - With no grant: ram_we=0 and ram_addr/ram_wdata hold the CPU values.
//  - cpu_stall = cpu_req & dma_granted. When stalled, the CPU re-presents the same access next cycle.
//  - DMA reads:
//    - dma_rdata = ram_rdata during dma_ack.
//    - A holding register captures that value and drives dma_rdata afterwards.
//  - DMA writes: dma_ack still pulses in t+1. The write is committed at the end of t.
//  - Simultaneous cpu_req and dma_req without force: CPU wins. dma_ack stays 0 and DMA keeps waiting.
//  - Reset: while reset=1, all grants are forced to 0.
//    - Outputs: ram_we=0, cpu_stall=0, dma_ack=0, dma_rdata=0, state=IDLE, wait counter=0.
//    - A DMA ack pending when reset asserts is discarded; the DMA master must re-issue the request.
//  - The block has no address range check. The caller gates cpu_req with the IO/memory decode.
// CONFIGURATION
//  DMEM_ARB_STARVE_GUARD_EN defined:
//    - An 8-bit wait counter increments each IDLE cycle in which dma_req=1 and DMA is not granted.
//    - Counter reaching MAX_WAIT forces a DMA grant in the next IDLE cycle with dma_req=1.
//      On a forced grant, cpu_stall=1 if cpu_req=1.
//    - The counter clears on any DMA grant and whenever dma_req=0.
//  DMEM_ARB_STARVE_GUARD_EN undefined:
//    - Strict CPU priority; DMA can starve indefinitely.
//    - MAX_WAIT is unused. No counter logic is generated.
// TESTING
//  1. CPU only: write 0xDEADBEEF to addr 3 with cpu_req=1/cpu_we=1; read addr 3 next cycle
//     -> cpu_rdata=0xDEADBEEF one cycle later; cpu_stall=0 throughout.
//  2. DMA only: write 0x12345678 to addr 31, then read addr 31
//     -> each dma_ack 1 cycle after grant; read-ack dma_rdata=0x12345678, held afterwards.
//  3. Contention: cpu_req=1 and dma_req=1 on the same cycle, guard off
//     -> CPU served, cpu_stall=0, no dma_ack; after cpu_req=0 -> DMA granted, ack next cycle.
//  4. Starvation, guard on, MAX_WAIT=4: cpu_req held 1, dma_req=1 at cycle 0
//     -> forced DMA grant at cycle 4; cpu_stall=1 that cycle only; dma_ack at cycle 5.
//  5. DMA burst: dma_req held high for 3 accesses with CPU idle
//     -> grants at cycles 0, 2, 4; acks at cycles 1, 3, 5; ram_we=0 on ack cycles.
//  6. Reset mid-DMA: assert reset in the cycle after a DMA read grant
//     -> dma_ack=0 and dma_rdata=0 immediately; after release, state=IDLE and a re-issued req completes normally.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single-port synchronous data RAM between the
// MEM-stage CPU port (fixed priority) and a req/ack DMA/loader port.
// Optional starvation guard: define DMEM_ARB_STARVE_GUARD_EN to enable the
// DMA wait counter that forces a DMA grant after MAX_WAIT lost cycles.
module dmem_port_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic {
    IDLE,
    DMA_ACK
  } state_t;

  state_t            state;
  logic              dma_grant;
  logic              cpu_grant;
  logic              dma_forced;
  logic [DATA_W-1:0] dma_rdata_hold;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam logic [7:0] MAX_WAIT_CNT = 8'(MAX_WAIT);

  logic [7:0] wait_cnt;

  assign dma_forced = (state == IDLE) && dma_req && (wait_cnt >= MAX_WAIT_CNT);

  // Count IDLE cycles in which a pending DMA request lost to the CPU; saturates at 255.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt <= 8'd0;
    end else if (!dma_req || dma_grant) begin
      wait_cnt <= 8'd0;
    end else if ((state == IDLE) && (wait_cnt != 8'hFF)) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end
`else
  assign dma_forced = 1'b0;
`endif

  // Grant decision is combinational; reset forces both grants off so the RAM is never written.
  always_comb begin
    dma_grant = 1'b0;
    cpu_grant = 1'b0;
    if (!reset) begin
      dma_grant = (state == IDLE) && dma_req && (!cpu_req || dma_forced);
      cpu_grant = cpu_req && !dma_grant;
    end
  end

  // RAM port follows the granted master; with no grant the CPU values pass through with we=0.
  always_comb begin
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    ram_we    = cpu_grant && cpu_we;
    if (dma_grant) begin
      ram_addr  = dma_addr;
      ram_wdata = dma_wdata;
      ram_we    = dma_we;
    end
  end

  // The ack state is entered the cycle after a DMA grant and always returns to IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else if (state == DMA_ACK) begin
      state <= IDLE;
    end else if (dma_grant) begin
      state <= DMA_ACK;
    end
  end

  // Capture the RAM output on the ack cycle so dma_rdata stays valid until the next ack.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dma_rdata_hold <= '0;
    end else if (state == DMA_ACK) begin
      dma_rdata_hold <= ram_rdata;
    end
  end

  assign dma_ack   = (state == DMA_ACK);
  assign dma_rdata = dma_ack ? ram_rdata : dma_rdata_hold;
  assign cpu_rdata = ram_rdata;
  assign cpu_stall = cpu_req && dma_grant;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed bench for dmem_port_arbiter with a behavioural
// synchronous RAM. Read data is checked by a scoreboard monitor; per-cycle
// stall/we/ack expectations are checked by the stimulus process.
module tb_dmem_port_arbiter;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int MAX_WAIT = 4;

  typedef struct {
    logic              is_read;
    logic [DATA_W-1:0] data;
  } dma_exp_t;

  logic              clock;
  logic              reset;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_ack;
  logic [DATA_W-1:0] dma_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic [DATA_W-1:0] mem [0:31];
  logic              cpu_rd_issue;
  logic              cpu_rd_check;

  dma_exp_t          dma_q[$];
  logic [DATA_W-1:0] cpu_q[$];

  int n_cmp;
  int n_fail;

  dmem_port_arbiter #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .dma_req  (dma_req),
    .dma_we   (dma_we),
    .dma_addr (dma_addr),
    .dma_wdata(dma_wdata),
    .dma_ack  (dma_ack),
    .dma_rdata(dma_rdata),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Behavioural single-port RAM: write-then-read-old, one-cycle read latency.
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    ram_rdata = '0;
  end

  always @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // A CPU read issued in cycle t has its data checked in t+1.
  always @(posedge clock) begin
    cpu_rd_check <= cpu_rd_issue;
  end

  task automatic checkValue(input string name, input logic [DATA_W-1:0] act,
                            input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: pops expected read data whenever the DUT presents a result.
  always @(negedge clock) begin
    if (!reset) begin
      if (cpu_rd_check) begin
        if (cpu_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL cpu_rdata_unexpected: got 0x%08h expected no read", cpu_rdata);
        end else begin
          checkValue("cpu_rdata", cpu_rdata, cpu_q.pop_front());
        end
      end
      if (dma_ack) begin
        if (dma_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL dma_ack_unexpected: got ack=1 expected ack=0 at %0t", $time);
        end else begin
          dma_exp_t e;
          e = dma_q.pop_front();
          n_cmp++;
          if (e.is_read) checkValue("dma_rdata_ack", dma_rdata, e.data);
        end
      end
    end
  end

  task automatic applyStimulus(input logic c_req, input logic c_we, input logic [ADDR_W-1:0] c_addr,
                               input logic [DATA_W-1:0] c_wdata, input logic d_req, input logic d_we,
                               input logic [ADDR_W-1:0] d_addr, input logic [DATA_W-1:0] d_wdata);
    cpu_req   = c_req;
    cpu_we    = c_we;
    cpu_addr  = c_addr;
    cpu_wdata = c_wdata;
    dma_req   = d_req;
    dma_we    = d_we;
    dma_addr  = d_addr;
    dma_wdata = d_wdata;
  endtask

  task automatic checkOutput(input string name, input logic stall, input logic we, input logic ack);
    @(negedge clock);
    checkValue({name, "_stall"}, {31'd0, cpu_stall}, {31'd0, stall});
    checkValue({name, "_ram_we"}, {31'd0, ram_we}, {31'd0, we});
    checkValue({name, "_dma_ack"}, {31'd0, dma_ack}, {31'd0, ack});
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic cycle(input string name, input logic stall, input logic we, input logic ack);
    checkOutput(name, stall, we, ack);
    step();
  endtask

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_fail = 0;
    cpu_rd_issue = 1'b0;
    reset = 1'b1;

    // Reset: both masters requesting, nothing may reach the RAM.
    applyStimulus(1'b1, 1'b1, 5'd1, 32'h1111_1111, 1'b1, 1'b1, 5'd2, 32'h2222_2222);
    checkOutput("reset", 1'b0, 1'b0, 1'b0);
    checkValue("reset_dma_rdata", dma_rdata, 32'h0);
    step();
    step();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    reset = 1'b0;
    step();

    // 1. CPU write then read of addr 3.
    applyStimulus(1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0, 1'b0, 5'd0, 32'h0);
    cycle("cpu_wr", 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 5'd3, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    cpu_q.push_back(32'hDEAD_BEEF);
    cpu_rd_issue = 1'b1;
    cycle("cpu_rd", 1'b0, 1'b0, 1'b0);
    cpu_rd_issue = 1'b0;
    applyStimulus(1'b0, 1'b0, 5'd3, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    cycle("cpu_idle", 1'b0, 1'b0, 1'b0);

    // 2. DMA write then read of addr 31, then check the read data is held.
    applyStimulus(1'b0, 1'b0, 5'd3, 32'h0, 1'b1, 1'b1, 5'd31, 32'h1234_5678);
    dma_q.push_back('{is_read: 1'b0, data: '0});
    cycle("dma_wr_grant", 1'b0, 1'b1, 1'b0);
    cycle("dma_wr_ack", 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 5'd3, 32'h0, 1'b1, 1'b0, 5'd31, 32'h0);
    dma_q.push_back('{is_read: 1'b1, data: 32'h1234_5678});
    cycle("dma_rd_grant", 1'b0, 1'b0, 1'b0);
    cycle("dma_rd_ack", 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 5'd3, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("dma_hold1", 1'b0, 1'b0, 1'b0);
    checkValue("dma_rdata_hold1", dma_rdata, 32'h1234_5678);
    step();
    applyStimulus(1'b0, 1'b0, 5'd3, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("dma_hold2", 1'b0, 1'b0, 1'b0);
    checkValue("dma_rdata_hold2", dma_rdata, 32'h1234_5678);
    step();

    // 3. Contention: CPU wins, DMA waits, then goes once CPU drops.
    applyStimulus(1'b1, 1'b0, 5'd3, 32'h0, 1'b1, 1'b1, 5'd5, 32'hA5A5_A5A5);
    dma_q.push_back('{is_read: 1'b0, data: '0});
    cycle("cont_cpu", 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 5'd3, 32'h0, 1'b1, 1'b1, 5'd5, 32'hA5A5_A5A5);
    cycle("cont_dma_grant", 1'b0, 1'b1, 1'b0);
    cycle("cont_dma_ack", 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 5'd5, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    cpu_q.push_back(32'hA5A5_A5A5);
    cpu_rd_issue = 1'b1;
    cycle("cont_cpu_rd", 1'b0, 1'b0, 1'b0);
    cpu_rd_issue = 1'b0;
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    cycle("cont_idle", 1'b0, 1'b0, 1'b0);

    // 4. Starvation: CPU holds the port while DMA reads addr 5.
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd5, 32'h0);
    dma_q.push_back('{is_read: 1'b1, data: 32'hA5A5_A5A5});
`ifdef DMEM_ARB_STARVE_GUARD_EN
    for (int i = 0; i < MAX_WAIT; i++) cycle("starve_wait", 1'b0, 1'b0, 1'b0);
    cycle("starve_force", 1'b1, 1'b0, 1'b0);
    cycle("starve_ack", 1'b0, 1'b0, 1'b1);
`else
    for (int i = 0; i < 2 * MAX_WAIT; i++) cycle("starve_wait", 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd5, 32'h0);
    cycle("starve_release", 1'b0, 1'b0, 1'b0);
    cycle("starve_ack", 1'b0, 1'b0, 1'b1);
`endif
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    cycle("starve_idle", 1'b0, 1'b0, 1'b0);

    // 5. DMA burst: req held high for three writes, one access every two cycles.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'(10 + i), 32'(16 + i));
      dma_q.push_back('{is_read: 1'b0, data: '0});
      cycle("burst_grant", 1'b0, 1'b1, 1'b0);
      cycle("burst_ack", 1'b0, 1'b0, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd11, 32'h0);
    dma_q.push_back('{is_read: 1'b1, data: 32'd17});
    cycle("burst_rd_grant", 1'b0, 1'b0, 1'b0);
    cycle("burst_rd_ack", 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    cycle("burst_idle", 1'b0, 1'b0, 1'b0);

    // 6. Reset in the cycle after a DMA read grant discards the pending ack.
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd31, 32'h0);
    cycle("rst_dma_grant", 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    checkOutput("rst_mid", 1'b0, 1'b0, 1'b0);
    checkValue("rst_mid_dma_rdata", dma_rdata, 32'h0);
    step();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    reset = 1'b0;
    cycle("rst_release", 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd31, 32'h0);
    dma_q.push_back('{is_read: 1'b1, data: 32'h1234_5678});
    cycle("rst_reissue_grant", 1'b0, 1'b0, 1'b0);
    cycle("rst_reissue_ack", 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    cycle("final_idle", 1'b0, 1'b0, 1'b0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 20 && (dma_q.size() != 0 || cpu_q.size() != 0); i++) step();
    n_cmp++;
    if (dma_q.size() != 0 || cpu_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: got %0d dma / %0d cpu pending expected 0 / 0",
               dma_q.size(), cpu_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
